// File: rtl/heichips25_project_switcher.sv
// rtl/heichips25_project_switcher.sv - glitch-free ena/reset handover controller for the two-project wrapper
module heichips25_project_switcher #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel_valid,
  input  logic sel_proj,
  output logic sel_ready,
  input  logic ext_rst_n,
  output logic ena,
  output logic proj_rst_n,
  output logic busy,
  output logic switch_done
);

  localparam int MAX_CYCLES = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT,
    IDLE,
    DRAIN,
    SETTLE
  } state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic          target;
  logic          ext_meta;
  logic          ext_s;
  logic          rel;
  logic          accept;

  // The project is only released from reset while parked in IDLE.
  assign rel       = (state == IDLE);
  assign sel_ready = rel & ext_s;
  assign busy      = ~rel;
  assign accept    = sel_valid & sel_ready;

  // Two-flop synchroniser for the asynchronous external project reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_meta <= 1'b0;
      ext_s    <= 1'b0;
    end else begin
      ext_meta <= ext_rst_n;
      ext_s    <= ext_meta;
    end
  end

  // Registered project reset: low whenever a sequence runs or the external request is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proj_rst_n <= 1'b0;
    end else begin
      proj_rst_n <= rel & ext_s;
    end
  end

  // Handover sequencer: hold reset, swap ena, let the design settle, then release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      counter     <= SETTLE_LOAD;
      ena         <= 1'b0;
      target      <= 1'b0;
      switch_done <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      case (state)
        BOOT: begin
          if (counter == '0) begin
            state <= IDLE;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            if (sel_proj == ena) begin
              switch_done <= 1'b1;
            end else begin
              target  <= sel_proj;
              counter <= RST_LOAD;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (counter == '0) begin
            ena     <= target;
            counter <= SETTLE_LOAD;
            state   <= SETTLE;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        SETTLE: begin
          if (counter == '0) begin
            state       <= IDLE;
            switch_done <= 1'b1;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
